// File: rtl/seqdet_stream_ctrl_if.sv
// Parallel-in / serial-out stream bundle between a word producer and the
// bit-serial sequence detector.
interface seqdet_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bit_out;
    logic              bit_valid;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  bit_out,
        input  bit_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output bit_out,
        output bit_valid
    );
endinterface

// File: rtl/seqdet_stream_ctrl.sv
// Word-to-bit serializer (MSB first) with a run-time programmable, overlapping
// bit-pattern detector and a saturating match counter.
module seqdet_stream_ctrl #(
    parameter int                 DATA_W      = 8,
    parameter int                 PAT_MAX     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [PAT_MAX-1:0] DEF_PATTERN = 8'b0000_0101,
    parameter logic [3:0]         DEF_LEN     = 4'd3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    seqdet_stream_ctrl_if.slave s,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         present_state
);

    localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int                FILL_W   = $clog2(PAT_MAX + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_MAX);
    localparam logic [FILL_W:0]   FILL_ONE = (FILL_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_e;

    state_e             state_q,     state_d;
    logic [DATA_W-1:0]  shreg_q,     shreg_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               bit_out_q,   bit_out_d;
    logic               bit_valid_q, bit_valid_d;
    logic               match_q,     match_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [PAT_MAX-1:0] pat_q,       pat_d;
    logic [3:0]         len_q,       len_d;
    logic [PAT_MAX-1:0] hist_q,      hist_d;
    logic [FILL_W-1:0]  fill_q,      fill_d;

    logic               last_bit_s;
    logic               in_ready_s;
    logic               hs_s;
    logic               cfg_ok_s;
    logic [PAT_MAX-1:0] hist_next_s;
    logic [PAT_MAX-1:0] mask_s;
    logic [FILL_W:0]    fill_plus_s;
    logic               hit_s;

    assign last_bit_s  = (state_q == ST_SHIFT) && (idx_q == IDX_LAST);
    assign in_ready_s  = ena && !cfg_we && ((state_q == ST_IDLE) || last_bit_s);
    assign hs_s        = in_ready_s && s.in_valid;
    assign cfg_ok_s    = ena && cfg_we && (state_q == ST_IDLE) && !bit_valid_q;
    assign hist_next_s = {hist_q[PAT_MAX-2:0], bit_out_q};
    assign fill_plus_s = {1'b0, fill_q} + FILL_ONE;

    // Window mask selecting the low len_q history bits for the compare.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask_s[i] = (i < int'(len_q));
        end
    end

    assign hit_s = (len_q != 4'd0)
                && (fill_plus_s >= (FILL_W + 1)'(len_q))
                && ((hist_next_s & mask_s) == (pat_q & mask_s));

    // Next-state, serializer, detector and counter update.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        match_d     = 1'b0;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        len_d       = len_q;
        hist_d      = hist_q;
        fill_d      = fill_q;

        if (ena) begin
            if (cfg_ok_s) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                hist_d = '0;
                fill_d = '0;
                cnt_d  = '0;
            end else begin
                if (match_q && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end

                if (bit_valid_q) begin
                    hist_d  = hist_next_s;
                    fill_d  = (fill_q == FILL_MAX) ? FILL_MAX : fill_plus_s[FILL_W-1:0];
                    match_d = hit_s;
                end else begin
                    match_d = 1'b0;
                end

                // A handshake on the last bit reloads directly, so words stream with no bubble.
                case (state_q)
                    ST_IDLE: begin
                        if (hs_s) begin
                            shreg_d     = s.in_data;
                            bit_out_d   = s.in_data[DATA_W-1];
                            bit_valid_d = 1'b1;
                            idx_d       = '0;
                            state_d     = ST_SHIFT;
                        end else begin
                            state_d     = ST_IDLE;
                        end
                    end
                    ST_SHIFT: begin
                        if (!last_bit_s) begin
                            bit_out_d = shreg_q[DATA_W-2];
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            idx_d     = idx_q + IDX_ONE;
                        end else if (hs_s) begin
                            shreg_d     = s.in_data;
                            bit_out_d   = s.in_data[DATA_W-1];
                            bit_valid_d = 1'b1;
                            idx_d       = '0;
                        end else begin
                            bit_valid_d = 1'b0;
                            state_d     = ST_IDLE;
                        end
                    end
                    default: begin
                        bit_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                endcase
            end
        end else begin
            match_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            match_q     <= 1'b0;
            cnt_q       <= '0;
            pat_q       <= DEF_PATTERN;
            len_q       <= DEF_LEN;
            hist_q      <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            match_q     <= match_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
        end
    end

    assign s.in_ready    = in_ready_s;
    assign s.bit_out     = bit_out_q;
    assign s.bit_valid   = bit_valid_q;
    assign match         = match_q;
    assign match_count   = cnt_q;
    assign present_state = state_q;

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Directed bench for seqdet_stream_ctrl: default pattern, back-to-back words,
// reconfiguration, config/handshake priority, saturation, pause and reset.
module tb_seqdet_stream_ctrl;

    logic        clk;
    logic        reset;
    logic        ena;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        match;
    logic [15:0] match_count;
    logic [1:0]  present_state;
    logic        match2;
    logic [3:0]  match_count2;
    logic [1:0]  present_state2;

    int passed;
    int total;

    seqdet_stream_ctrl_if #(.DATA_W(8)) sif ();
    seqdet_stream_ctrl_if #(.DATA_W(8)) sif2 ();

    seqdet_stream_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ena(ena), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .s(sif),
        .match(match), .match_count(match_count), .present_state(present_state)
    );

    seqdet_stream_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .ena(ena), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .s(sif2),
        .match(match2), .match_count(match_count2), .present_state(present_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        ena           = 1'b1;
        cfg_we        = 1'b0;
        sif.in_valid  = 1'b0;
        sif2.in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (present_state !== 2'd0) $display("FAIL reset_state got %0d want 0", present_state); else passed++;
        total++; if (sif.bit_out !== 1'b0) $display("FAIL reset_bit_out got %b want 0", sif.bit_out); else passed++;
        total++; if (sif.bit_valid !== 1'b0) $display("FAIL reset_bit_valid got %b want 0", sif.bit_valid); else passed++;
        total++; if (match !== 1'b0) $display("FAIL reset_match got %b want 0", match); else passed++;
        total++; if (match_count !== 16'd0) $display("FAIL reset_count got %0d want 0", match_count); else passed++;
        total++; if (sif.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", sif.in_ready); else passed++;
    endtask

    task automatic test_single_word();
        logic [7:0] bits;
        logic [7:0] exp_m;
        bits  = 8'hAA;
        exp_m = 8'b1010_1000;
        do_reset();
        sif.in_data  = 8'hAA;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++; if (sif.bit_out !== bits[7-k]) $display("FAIL single_bit%0d got %b want %b", k, sif.bit_out, bits[7-k]); else passed++;
            total++; if (sif.bit_valid !== 1'b1) $display("FAIL single_valid%0d got %b want 1", k, sif.bit_valid); else passed++;
            total++; if (match !== exp_m[k]) $display("FAIL single_match%0d got %b want %b", k, match, exp_m[k]); else passed++;
            tick();
        end
        total++; if (sif.bit_valid !== 1'b0) $display("FAIL single_valid_drop got %b want 0", sif.bit_valid); else passed++;
        total++; if (present_state !== 2'd0) $display("FAIL single_state_idle got %0d want 0", present_state); else passed++;
        tick();
        tick();
        total++; if (match_count !== 16'd3) $display("FAIL single_count got %0d want 3", match_count); else passed++;
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        do_reset();
        sif.in_data  = 8'hAA;
        sif.in_valid = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            total++; if (sif.bit_valid !== 1'b1) $display("FAIL b2b_valid%0d got %b want 1", k, sif.bit_valid); else passed++;
            total++; if (sif.bit_out !== ((k % 2) == 0)) $display("FAIL b2b_bit%0d got %b want %b", k, sif.bit_out, ((k % 2) == 0)); else passed++;
            if (k == 7) begin
                total++; if (sif.in_ready !== 1'b1) $display("FAIL b2b_ready_last got %b want 1", sif.in_ready); else passed++;
            end
            if (k == 8) sif.in_valid = 1'b0;
            if (match === 1'b1) seen++;
            tick();
        end
        total++; if (sif.bit_valid !== 1'b0) $display("FAIL b2b_valid_end got %b want 0", sif.bit_valid); else passed++;
        total++; if (seen !== 7) $display("FAIL b2b_pulses got %0d want 7", seen); else passed++;
        tick();
        tick();
        total++; if (match_count !== 16'd7) $display("FAIL b2b_count got %0d want 7", match_count); else passed++;
    endtask

    task automatic test_config();
        int seen;
        seen        = 0;
        cfg_pattern = 8'b0000_1111;
        cfg_len     = 4'd4;
        cfg_we      = 1'b1;
        tick();
        cfg_we = 1'b0;
        total++; if (match_count !== 16'd0) $display("FAIL cfg_count_clear got %0d want 0", match_count); else passed++;
        sif.in_data  = 8'hF0;
        sif.in_valid = 1'b1;
        tick();
        sif.in_data = 8'h0F;
        for (int k = 0; k < 18; k++) begin
            if (k == 8) sif.in_valid = 1'b0;
            if (k == 4) begin
                total++; if (match !== 1'b1) $display("FAIL cfg_match_first got %b want 1", match); else passed++;
            end
            if (match === 1'b1) seen++;
            tick();
        end
        total++; if (seen !== 2) $display("FAIL cfg_pulses got %0d want 2", seen); else passed++;
        tick();
        total++; if (match_count !== 16'd2) $display("FAIL cfg_count got %0d want 2", match_count); else passed++;
    endtask

    task automatic test_cfg_in_shift();
        do_reset();
        sif.in_data  = 8'hAA;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        tick();
        tick();
        cfg_pattern = 8'hFF;
        cfg_len     = 4'd1;
        cfg_we      = 1'b1;
        #1;
        total++; if (sif.in_ready !== 1'b0) $display("FAIL shiftcfg_ready got %b want 0", sif.in_ready); else passed++;
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        total++; if (match_count !== 16'd3) $display("FAIL shiftcfg_count got %0d want 3", match_count); else passed++;
        sif.in_data  = 8'h05;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        for (int k = 0; k < 11; k++) tick();
        total++; if (match_count !== 16'd4) $display("FAIL shiftcfg_oldpat got %0d want 4", match_count); else passed++;
    endtask

    task automatic test_cfg_and_valid();
        do_reset();
        cfg_pattern  = 8'h01;
        cfg_len      = 4'd1;
        cfg_we       = 1'b1;
        sif.in_data  = 8'hA5;
        sif.in_valid = 1'b1;
        #1;
        total++; if (sif.in_ready !== 1'b0) $display("FAIL cfgvalid_ready got %b want 0", sif.in_ready); else passed++;
        tick();
        total++; if (present_state !== 2'd0) $display("FAIL cfgvalid_not_accepted got %0d want 0", present_state); else passed++;
        cfg_we = 1'b0;
        #1;
        total++; if (sif.in_ready !== 1'b1) $display("FAIL cfgvalid_ready_next got %b want 1", sif.in_ready); else passed++;
        tick();
        sif.in_valid = 1'b0;
        total++; if (present_state !== 2'd1) $display("FAIL cfgvalid_accept_state got %0d want 1", present_state); else passed++;
        total++; if (sif.bit_out !== 1'b1) $display("FAIL cfgvalid_first_bit got %b want 1", sif.bit_out); else passed++;
        for (int k = 0; k < 12; k++) tick();
        total++; if (match_count !== 16'd4) $display("FAIL cfgvalid_count got %0d want 4", match_count); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        cfg_pattern = 8'h01;
        cfg_len     = 4'd1;
        cfg_we      = 1'b1;
        tick();
        cfg_we        = 1'b0;
        sif2.in_data  = 8'hFF;
        sif2.in_valid = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) tick();
        sif2.in_valid = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        total++; if (match_count2 !== 4'd15) $display("FAIL sat_count got %0d want 15", match_count2); else passed++;
        total++; if (present_state2 !== 2'd0) $display("FAIL sat_state got %0d want 0", present_state2); else passed++;
        for (int k = 0; k < 5; k++) tick();
        total++; if (match_count2 !== 4'd15) $display("FAIL sat_hold got %0d want 15", match_count2); else passed++;
    endtask

    task automatic test_pause_reset();
        logic [7:0] bits;
        bits = 8'hC3;
        do_reset();
        sif.in_data  = 8'hC3;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++; if (sif.bit_out !== bits[7-k]) $display("FAIL pause_bit%0d got %b want %b", k, sif.bit_out, bits[7-k]); else passed++;
            if (k == 3) begin
                ena = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    tick();
                    total++; if (sif.bit_out !== bits[4]) $display("FAIL pause_hold%0d got %b want %b", p, sif.bit_out, bits[4]); else passed++;
                    total++; if (sif.in_ready !== 1'b0) $display("FAIL pause_ready%0d got %b want 0", p, sif.in_ready); else passed++;
                end
                ena = 1'b1;
            end
            tick();
        end
        sif.in_data  = 8'hAA;
        sif.in_valid = 1'b1;
        tick();
        sif.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (sif.bit_out !== 1'b0) $display("FAIL rst_bit_out got %b want 0", sif.bit_out); else passed++;
        total++; if (sif.bit_valid !== 1'b0) $display("FAIL rst_bit_valid got %b want 0", sif.bit_valid); else passed++;
        total++; if (match !== 1'b0) $display("FAIL rst_match got %b want 0", match); else passed++;
        total++; if (match_count !== 16'd0) $display("FAIL rst_count got %0d want 0", match_count); else passed++;
        total++; if (present_state !== 2'd0) $display("FAIL rst_state got %0d want 0", present_state); else passed++;
        total++; if (sif.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", sif.in_ready); else passed++;
        tick();
        total++; if (sif.bit_valid !== 1'b0) $display("FAIL rst_discard got %b want 0", sif.bit_valid); else passed++;
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset         = 1'b1;
        ena           = 1'b0;
        cfg_we        = 1'b0;
        cfg_pattern   = 8'h00;
        cfg_len       = 4'd0;
        sif.in_valid  = 1'b0;
        sif.in_data   = 8'h00;
        sif2.in_valid = 1'b0;
        sif2.in_data  = 8'h00;
        tick();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_config();
        test_cfg_in_shift();
        test_cfg_and_valid();
        test_saturation();
        test_pause_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seqdet_stream_ctrl.md
# seqdet_stream_ctrl

Byte-stream scheduler and programmable pattern detector that feeds the serial sequence-detection path. It accepts parallel words over a valid/ready handshake and serializes them MSB-first onto a one-bit stream. It checks that stream for a run-time-programmed bit pattern with overlapping matches, and keeps a saturating match count. It sits between a parallel producer and the serial detector datapath, replacing hand-driven `input_bit` stimulus with a scheduled, back-to-back bit stream.

## Interface
- `DATA_W`, 8, input word width in bits (serialized MSB first)
- `PAT_MAX`, 8, maximum pattern length in bits
- `CNT_W`, 16, match counter width
- `DEF_PATTERN`, 8'b0000_0101, pattern loaded at reset (right-aligned)
- `DEF_LEN`, 3, pattern length loaded at reset

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; dominates every other input
- `ena`  in  1  global enable; low freezes all state
- `cfg_we`  in  1  configuration write strobe
- `cfg_pattern`  in  PAT_MAX  new pattern, right-aligned (bit 0 = most recent bit)
- `cfg_len`  in  4  new length, 1..PAT_MAX; 0 disables detection
- `in_valid`  in  1  producer has a word
- `in_data`  in  DATA_W  word to serialize
- `in_ready`  out  1  word accepted on this edge when `in_valid` is also high
- `bit_out`  out  1  current serial bit
- `bit_valid`  out  1  `bit_out` is live
- `match`  out  1  one-cycle pulse per detected pattern occurrence
- `match_count`  out  CNT_W  saturating count of matches
- `present_state`  out  2  FSM state: 0 = IDLE, 1 = SHIFT

## Operation
- Reset values:
  - `present_state` = IDLE.
  - `bit_out`, `bit_valid`, `match` = 0.
  - `match_count` = 0.
  - Pattern = `DEF_PATTERN`, length = `DEF_LEN`.
  - History = 0; fill counter = 0; bit index = 0.
- `in_ready` is a combinational output: `ena & ~cfg_we & (IDLE | (SHIFT & idx == DATA_W-1))`.
- IDLE:
  - On handshake: shift register <= `in_data`, `bit_out` <= `in_data[DATA_W-1]`, `bit_valid` <= 1, idx <= 0, state -> SHIFT.
- SHIFT, each enabled edge:
  - If idx < DATA_W-1: `bit_out` <= next lower bit, idx <= idx+1.
  - If idx == DATA_W-1 and handshake: reload as in IDLE. No bubble between words.
  - If idx == DATA_W-1 and no handshake: state -> IDLE, `bit_valid` <= 0.
- Detection, on each enabled edge with `bit_valid` = 1:
  - hist <= {hist[PAT_MAX-2:0], bit_out}; fill <= min(fill+1, PAT_MAX).
  - `match` <= (cfg_len != 0) & (fill+1 >= cfg_len) & (low cfg_len bits of {hist[PAT_MAX-2:0], bit_out} == low cfg_len bits of pattern).
  - Matches overlap; history is not cleared after a match.
- On every other edge, `match` <= 0.
- `match_count` increments on each edge where `match` is 1 and saturates at 2^CNT_W-1.
- Configuration:
  - `cfg_we` takes effect only when `ena` = 1 and state = IDLE and `bit_valid` = 0. In any other case it is ignored.
  - On acceptance: pattern and length are loaded; hist, fill and `match_count` clear.
  - `cfg_we` blocks a handshake in the same cycle (configuration wins).
- `ena` = 0: no state, output, or counter changes. `match` is forced to 0 for the paused cycle and the pulse is not re-issued.
- `reset` mid-word: the word is discarded and all outputs return to reset values on that edge.

## Timing
- Accept on edge N: bit k of the word (k = 0 for the MSB) is on `bit_out` during the cycle after edge N+k (with `ena` continuously high).
- Match latency: `match` is high in the cycle after the edge that follows the completing bit's cycle, i.e. one cycle after that bit is on `bit_out`.
- `match_count` reflects a match one cycle after its `match` pulse.
- Throughput: one word per DATA_W cycles with back-to-back handshakes; one idle cycle is inserted only when `in_valid` is low at the last bit.
- Paused (`ena` low) cycles stretch all latencies 1:1.

## Test plan
- Reset, default pattern 101 with length 3, single word 8'hAA:
  - bit_out sequence is 1,0,1,0,1,0,1,0.
  - `match` pulses after bits 2, 4 and 6; `match_count` = 3.
  - `bit_valid` drops after 8 cycles and state returns to 0.
- Back-to-back 8'hAA, 8'hAA with `in_valid` held high:
  - No gap in `bit_valid`.
  - Matches include those spanning the word boundary; `match_count` = 7.
- Configure pattern 8'b0000_1111 with length 4, then send word 8'hF0 followed by 8'h0F:
  - Exactly 1 match (bits 0-3 of the first word), plus 1 match on bits 4-7 of the second word; total 2.
  - `match_count` was cleared at configuration.
- `cfg_we` asserted during SHIFT: the configuration is ignored and the old pattern still matches.
- `cfg_we` and `in_valid` asserted together in IDLE: the configuration loads, `in_ready` = 0, and the word is accepted on the next cycle.
- Run with `CNT_W` = 4, pattern length 1 with pattern 1, and three words of 8'hFF:
  - `match_count` saturates at 15 and stays there.
- `ena` held low for 3 cycles mid-word, then `reset` asserted mid-word:
  - During the pause, `bit_out` and idx hold and the resumed sequence is intact.
  - After reset, all outputs are 0, state is 0, and `in_ready` = 1 the next cycle with `ena` high.
